shd_wta_select: RTL and testbench



---
 rtl/stereo_pkg.sv | 17 +
 rtl/wta_cmp_node.sv | 37 +++
 rtl/shd_wta_select.sv | 127 ++++++++++++
 tb/tb_shd_wta_select.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline helpers: cost and disparity width derivation plus
// the saturated cost value used for masked candidates.
package stereo_pkg;

  function automatic int calc_nobit(input int wc, input int wh);
    return $clog2((wc * wc / 2) * wh * wh);
  endfunction

  function automatic int calc_dbit(input int d);
    return $clog2(d);
  endfunction

  function automatic logic [31:0] cost_max(input int nobit);
    return (32'h1 << nobit) - 32'h1;
  endfunction

endpackage

// File: rtl/wta_cmp_node.sv
// One registered 2:1 winner-take-all node: exclusion dominates cost,
// then the smaller cost wins, and an exact tie goes to the lower index.
module wta_cmp_node #(
  parameter int NOBIT = 12,
  parameter int DBIT  = 6
) (
  input  logic             clk,
  input  logic [NOBIT-1:0] a_cost,
  input  logic [DBIT-1:0]  a_idx,
  input  logic             a_excl,
  input  logic [NOBIT-1:0] b_cost,
  input  logic [DBIT-1:0]  b_idx,
  input  logic             b_excl,
  output logic [NOBIT-1:0] y_cost,
  output logic [DBIT-1:0]  y_idx,
  output logic             y_excl
);

  logic pick_a;

  always_comb begin
    pick_a = 1'b0;
    if (a_excl != b_excl)
      pick_a = b_excl;
    else if (a_cost != b_cost)
      pick_a = (a_cost < b_cost);
    else
      pick_a = (a_idx <= b_idx);
  end

  always_ff @(posedge clk) begin
    y_cost <= pick_a ? a_cost : b_cost;
    y_idx  <= pick_a ? a_idx  : b_idx;
    y_excl <= pick_a ? a_excl : b_excl;
  end

endmodule

// File: rtl/shd_wta_select.sv
// Winner-take-all disparity selector: border-masks D aggregated costs,
// reduces them through a registered binary tree and flags confidence.
module shd_wta_select
  import stereo_pkg::*;
#(
  parameter int D  = 64,
  parameter int WC = 7,
  parameter int WH = 13,
  parameter int M  = 650,
  localparam int NOBIT = calc_nobit(WC, WH),
  localparam int DBIT  = calc_dbit(D)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_dval,
  input  logic               i_sof,
  input  logic [D*NOBIT-1:0] i_data,
  input  logic [NOBIT-1:0]   i_thresh,
  output logic               o_dval,
  output logic [DBIT-1:0]    o_disp,
  output logic [NOBIT-1:0]   o_cost,
  output logic               o_conf
);

  localparam int CBIT = (M > 1) ? $clog2(M) : 1;

  logic [CBIT-1:0]  col;
  logic [CBIT-1:0]  col_cur;
  logic [NOBIT-1:0] leaf_cost [D];
  logic             leaf_excl [D];
  logic [NOBIT-1:0] thr_pipe  [DBIT+1];
  logic [DBIT:0]    vld_pipe;
  logic [NOBIT-1:0] node_cost [D-1];
  logic [DBIT-1:0]  node_idx  [D-1];
  logic             node_excl [D-1];

  // A start-of-frame beat is column 0 even when the counter is about to wrap.
  assign col_cur = i_sof ? '0 : col;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      col <= '0;
    else if (i_dval) begin
      if (i_sof)
        col <= CBIT'(1);
      else if (col == CBIT'(M - 1))
        col <= '0;
      else
        col <= col + CBIT'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int d = 0; d < D; d++) begin
      leaf_excl[d] <= (d > int'(col_cur));
      leaf_cost[d] <= (d > int'(col_cur)) ? NOBIT'(cost_max(NOBIT))
                                         : i_data[d*NOBIT +: NOBIT];
    end
    thr_pipe[0] <= i_thresh;
    for (int k = 1; k <= DBIT; k++)
      thr_pipe[k] <= thr_pipe[k-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      vld_pipe <= '0;
    else
      vld_pipe <= {vld_pipe[DBIT-1:0], i_dval};
  end

  // Heap layout: node n has children 2n+1 and 2n+2, leaves sit after node D-2,
  // so the left child always covers the lower lane indices.
  for (genvar n = 0; n < D - 1; n++) begin : g_node
    localparam int L = 2 * n + 1;
    localparam int R = 2 * n + 2;
    logic [NOBIT-1:0] a_cost, b_cost;
    logic [DBIT-1:0]  a_idx, b_idx;
    logic             a_excl, b_excl;

    if (L >= D - 1) begin : g_leaf
      assign a_cost = leaf_cost[L-(D-1)];
      assign a_idx  = DBIT'(L - (D - 1));
      assign a_excl = leaf_excl[L-(D-1)];
      assign b_cost = leaf_cost[R-(D-1)];
      assign b_idx  = DBIT'(R - (D - 1));
      assign b_excl = leaf_excl[R-(D-1)];
    end else begin : g_inner
      assign a_cost = node_cost[L];
      assign a_idx  = node_idx[L];
      assign a_excl = node_excl[L];
      assign b_cost = node_cost[R];
      assign b_idx  = node_idx[R];
      assign b_excl = node_excl[R];
    end

    wta_cmp_node #(
      .NOBIT (NOBIT),
      .DBIT  (DBIT)
    ) u_node (
      .clk    (i_clk),
      .a_cost (a_cost),
      .a_idx  (a_idx),
      .a_excl (a_excl),
      .b_cost (b_cost),
      .b_idx  (b_idx),
      .b_excl (b_excl),
      .y_cost (node_cost[n]),
      .y_idx  (node_idx[n]),
      .y_excl (node_excl[n])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dval <= 1'b0;
      o_disp <= '0;
      o_cost <= '0;
      o_conf <= 1'b0;
    end else begin
      o_dval <= vld_pipe[DBIT];
      o_disp <= node_idx[0];
      o_cost <= node_cost[0];
      o_conf <= (node_cost[0] <= thr_pipe[DBIT]);
    end
  end

endmodule

// File: tb/tb_shd_wta_select.sv
// Directed and scoreboard checks of shd_wta_select with a small D=4/M=5
// instance for corner cases and the default D=64 instance for random traffic.
module tb_shd_wta_select;
  import stereo_pkg::*;

  localparam int NB    = calc_nobit(7, 13);
  localparam int LAT4  = 4;
  localparam int LAT64 = 8;

  typedef struct {
    logic sof;
    int   c0, c1, c2, c3;
    int   th;
    int   disp;
    int   cost;
    logic conf;
  } vec_t;

  typedef struct {
    int   disp;
    int   cost;
    logic conf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            dval4, sof4;
  logic [4*NB-1:0] data4;
  logic [NB-1:0]   th4;
  logic            odval4;
  logic [1:0]      disp4;
  logic [NB-1:0]   cost4;
  logic            conf4;

  logic             dval64, sof64;
  logic [64*NB-1:0] data64;
  logic [NB-1:0]    th64;
  logic             odval64;
  logic [5:0]       disp64;
  logic [NB-1:0]    cost64;
  logic             conf64;

  int errors = 0;
  int checks = 0;

  shd_wta_select #(.D(4), .WC(7), .WH(13), .M(5)) u_dut4 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_dval   (dval4),
    .i_sof    (sof4),
    .i_data   (data4),
    .i_thresh (th4),
    .o_dval   (odval4),
    .o_disp   (disp4),
    .o_cost   (cost4),
    .o_conf   (conf4)
  );

  shd_wta_select #(.D(64), .WC(7), .WH(13), .M(650)) u_dut64 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_dval   (dval64),
    .i_sof    (sof64),
    .i_data   (data64),
    .i_thresh (th64),
    .o_dval   (odval64),
    .o_disp   (disp64),
    .o_cost   (cost64),
    .o_conf   (conf64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive4(input logic sof, input int c0, input int c1, input int c2, input int c3,
                        input int th);
    data4 = {NB'(c3), NB'(c2), NB'(c1), NB'(c0)};
    th4   = NB'(th);
    sof4  = sof;
    dval4 = 1'b1;
  endtask

  // One beat, then idle cycles with a stray sof that must be ignored.
  task automatic apply_stimulus(input vec_t v);
    drive4(v.sof, v.c0, v.c1, v.c2, v.c3, v.th);
    tick();
    dval4 = 1'b0;
    sof4  = 1'b1;
    for (int i = 0; i < LAT4 - 1; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[15];
    int   pat[9];
    int   pdisp[6];
    int   pcost[6];
    int   b;
    logic [NB-1:0] cst[64];
    int   mcol;
    res_t exp_q[$];
    bit   vq[$];

    vecs[0]  = '{1'b1,   50,   1,    1, 1,   60,   0,   50, 1'b1};
    vecs[1]  = '{1'b0,   50,   1,    1, 1,    0,   1,    1, 1'b0};
    vecs[2]  = '{1'b0,   40,  12,   30, 12,  20,   1,   12, 1'b1};
    vecs[3]  = '{1'b0,   40,  12,   30, 12,  20,   1,   12, 1'b1};
    vecs[4]  = '{1'b0,    9,   9,    9, 9,    9,   0,    9, 1'b1};
    vecs[5]  = '{1'b0,  100,   5,    5, 5,   99,   0,  100, 1'b0};
    vecs[6]  = '{1'b0, 4095, 4095,   7, 7, 4095,   0, 4095, 1'b1};
    vecs[7]  = '{1'b0, 4095, 4095, 4095, 0,   0,   0, 4095, 1'b0};
    vecs[8]  = '{1'b0, 4095, 4095, 4095, 0,   0,   3,    0, 1'b1};
    vecs[9]  = '{1'b1,   30,   2,    2, 2,   30,   0,   30, 1'b1};
    vecs[10] = '{1'b0,   30,  20,    2, 2,   19,   1,   20, 1'b0};
    vecs[11] = '{1'b0,    8,   6,    5, 1,    5,   2,    5, 1'b1};
    vecs[12] = '{1'b0,    8,   6,    5, 1,    0,   3,    1, 1'b0};
    vecs[13] = '{1'b1,    7,   3,    3, 3,    7,   0,    7, 1'b1};
    vecs[14] = '{1'b0,    7,   3,    3, 3,    2,   1,    3, 1'b0};

    rst = 1'b1;
    dval4 = 1'b0; sof4 = 1'b0; data4 = '0; th4 = '0;
    dval64 = 1'b0; sof64 = 1'b0; data64 = '0; th64 = '0;
    tick();
    tick();
    check_output("reset dval4", 32'(odval4), 0);
    check_output("reset disp4", 32'(disp4), 0);
    check_output("reset cost4", 32'(cost4), 0);
    check_output("reset conf4", 32'(conf4), 0);
    check_output("reset dval64", 32'(odval64), 0);
    check_output("reset disp64", 32'(disp64), 0);
    check_output("reset cost64", 32'(cost64), 0);
    check_output("reset conf64", 32'(conf64), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d dval", i), 32'(odval4), 1);
      check_output($sformatf("vec%0d disp", i), 32'(disp4), 32'(vecs[i].disp));
      check_output($sformatf("vec%0d cost", i), 32'(cost4), 32'(vecs[i].cost));
      check_output($sformatf("vec%0d conf", i), 32'(conf4), 32'(vecs[i].conf));
    end
    sof4 = 1'b0;

    // Threshold changes while a beat is in flight must not affect it.
    drive4(1'b1, 21, 30, 30, 30, 20);
    tick();
    dval4 = 1'b0; sof4 = 1'b0; th4 = NB'(25);
    for (int i = 0; i < LAT4 - 1; i++) tick();
    check_output("thresh lo cost", 32'(cost4), 21);
    check_output("thresh lo conf", 32'(conf4), 0);
    drive4(1'b0, 21, 30, 30, 30, 25);
    tick();
    dval4 = 1'b0; th4 = NB'(0);
    for (int i = 0; i < LAT4 - 1; i++) tick();
    check_output("thresh hi conf", 32'(conf4), 1);

    // Valid gaps, column advance on valid beats only, and wrap at M-1.
    pat   = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
    pdisp = '{0, 1, 2, 3, 3, 0};
    pcost = '{40, 30, 20, 10, 10, 40};
    b = 0;
    data4 = {NB'(10), NB'(20), NB'(30), NB'(40)};
    th4 = NB'(4095);
    for (int t = 0; t < 9 + LAT4; t++) begin
      int k;
      logic ev;
      dval4 = (t < 9) ? pat[t][0] : 1'b0;
      sof4  = (t == 0);
      tick();
      k  = t - (LAT4 - 1);
      ev = (k >= 0 && k < 9) ? pat[k][0] : 1'b0;
      check_output($sformatf("pattern dval t%0d", t), 32'(odval4), 32'(ev));
      if (ev && b < 6) begin
        check_output($sformatf("pattern disp b%0d", b), 32'(disp4), 32'(pdisp[b]));
        check_output($sformatf("pattern cost b%0d", b), 32'(cost4), 32'(pcost[b]));
        b++;
      end
    end
    sof4 = 1'b0;

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      drive4(1'b0, 40, 30, 20, 10, 4095);
      tick();
    end
    dval4 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midreset dval", 32'(odval4), 0);
    check_output("midreset disp", 32'(disp4), 0);
    check_output("midreset cost", 32'(cost4), 0);
    check_output("midreset conf", 32'(conf4), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output($sformatf("postreset idle dval c%0d", i), 32'(odval4), 0);
    end
    drive4(1'b0, 40, 30, 20, 10, 35);
    tick();
    dval4 = 1'b0;
    for (int i = 0; i < LAT4 - 1; i++) begin
      check_output($sformatf("postreset early dval c%0d", i), 32'(odval4), 0);
      tick();
    end
    check_output("postreset dval", 32'(odval4), 1);
    check_output("postreset disp", 32'(disp4), 0);
    check_output("postreset cost", 32'(cost4), 40);
    check_output("postreset conf", 32'(conf4), 0);

    // Random traffic on the D=64 instance against a reference argmin.
    mcol = 0;
    for (int it = 0; it < 1200 + LAT64; it++) begin
      logic v, s;
      logic ev;
      v = (it < 1200) && (it == 0 || $urandom_range(0, 3) != 0);
      s = v && (it == 0 || it == 900);
      if (v) begin
        int cur, bd, bc, th;
        for (int d = 0; d < 64; d++)
          cst[d] = ($urandom_range(0, 7) == 0) ? NB'(4095) : NB'($urandom_range(0, 200));
        th  = $urandom_range(0, 100);
        cur = s ? 0 : mcol;
        mcol = s ? 1 : ((mcol == 649) ? 0 : mcol + 1);
        bd = 0;
        bc = int'(cst[0]);
        for (int d = 1; d < 64; d++)
          if (d <= cur && int'(cst[d]) < bc) begin
            bd = d;
            bc = int'(cst[d]);
          end
        exp_q.push_back('{bd, bc, (bc <= th)});
        for (int d = 0; d < 64; d++) data64[d*NB +: NB] = cst[d];
        th64 = NB'(th);
      end
      dval64 = v;
      sof64  = s;
      vq.push_back(v);
      tick();
      ev = 1'b0;
      if (vq.size() == LAT64) ev = vq.pop_front();
      check_output($sformatf("rand dval it%0d", it), 32'(odval64), 32'(ev));
      if (ev && exp_q.size() > 0) begin
        res_t r;
        r = exp_q.pop_front();
        check_output($sformatf("rand disp it%0d", it), 32'(disp64), 32'(r.disp));
        check_output($sformatf("rand cost it%0d", it), 32'(cost64), 32'(r.cost));
        check_output($sformatf("rand conf it%0d", it), 32'(conf64), 32'(r.conf));
      end
    end
    check_output("rand leftover beats", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
